// File: rtl/led_pio_ctrl.sv
// led_pio_ctrl: Avalon-MM LED/GPIO output port with atomic SET/CLR/TOGGLE writes
// and an optional hardware blink engine, compiled in when LED_PIO_BLINK_EN is defined.
module led_pio_ctrl #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DIV_W     = 24,
  parameter logic [31:0] RESET_VAL = 32'h0
) (
  input  logic             clk_clk,
  input  logic             reset_reset,
  input  logic [2:0]       avs_address,
  input  logic             avs_read,
  input  logic             avs_write,
  input  logic [31:0]      avs_writedata,
  output logic [31:0]      avs_readdata,
  output logic [WIDTH-1:0] led_wire_export
);

  typedef enum logic [2:0] {
    ADDR_DATA   = 3'd0,
    ADDR_SET    = 3'd1,
    ADDR_CLR    = 3'd2,
    ADDR_TOGGLE = 3'd3,
    ADDR_MASK   = 3'd4,
    ADDR_DIV    = 3'd5,
    ADDR_STATUS = 3'd6,
    ADDR_RSVD   = 3'd7
  } reg_addr_e;

  reg_addr_e        addr;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] blink_bits;
  logic [31:0]      rd_mask;
  logic [31:0]      rd_div;
  logic [31:0]      rd_status;
  logic [31:0]      rd_mux;
  logic             unused_wdata;

  assign addr         = reg_addr_e'(avs_address);
  assign wdata        = avs_writedata[WIDTH-1:0];
  // Bits above WIDTH/DIV_W are deliberately dropped.
  assign unused_wdata = ^avs_writedata;

  // NOTE: registered state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      data_q <= RESET_VAL[WIDTH-1:0];
    end else if (avs_write) begin
      case (addr)
        ADDR_DATA:   data_q <= wdata;
        ADDR_SET:    data_q <= data_q | wdata;
        ADDR_CLR:    data_q <= data_q & ~wdata;
        ADDR_TOGGLE: data_q <= data_q ^ wdata;
        default:     ;
      endcase
    end
  end

`ifdef LED_PIO_BLINK_EN
  logic [WIDTH-1:0] mask_q;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] cnt_q;
  logic             phase_q;
  logic             div_wr;

  assign div_wr = avs_write && (addr == ADDR_DIV);

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      mask_q <= '0;
      div_q  <= '0;
    end else if (avs_write) begin
      if (addr == ADDR_MASK) mask_q <= wdata;
      if (addr == ADDR_DIV)  div_q  <= avs_writedata[DIV_W-1:0];
    end
  end

  // A BLINK_DIV write restarts the period, so a smaller divisor never wraps the counter.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else if (div_wr || (div_q == '0)) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else if (cnt_q == div_q) begin
      cnt_q   <= '0;
      phase_q <= ~phase_q;
    end else begin
      cnt_q   <= cnt_q + DIV_W'(1);
    end
  end

  assign blink_bits = mask_q & {WIDTH{phase_q}};
  assign rd_mask    = 32'(mask_q);
  assign rd_div     = 32'(div_q);
  assign rd_status  = {30'b0, (div_q != '0), phase_q};
`else
  assign blink_bits = '0;
  assign rd_mask    = '0;
  assign rd_div     = '0;
  assign rd_status  = '0;
`endif

  // NOTE: rd_mux gets its default first, so no path leaves it unassigned (no latch).
  always_comb begin
    rd_mux = '0;
    case (addr)
      ADDR_DATA:   rd_mux = 32'(data_q);
      ADDR_MASK:   rd_mux = rd_mask;
      ADDR_DIV:    rd_mux = rd_div;
      ADDR_STATUS: rd_mux = rd_status;
      default:     rd_mux = '0;
    endcase
  end

  // Read data is captured from pre-write state and held until the next read.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      avs_readdata <= '0;
    end else if (avs_read) begin
      avs_readdata <= rd_mux;
    end
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      led_wire_export <= RESET_VAL[WIDTH-1:0];
    end else begin
      led_wire_export <= data_q ^ blink_bits;
    end
  end

endmodule

// File: tb/tb_led_pio_ctrl.sv
// tb_led_pio_ctrl: directed scoreboard bench for led_pio_ctrl; covers both builds
// (blink checks run only when LED_PIO_BLINK_EN is defined).
module tb_led_pio_ctrl;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DIV_W = 24;
  localparam logic [31:0] RST_V = 32'hA5;

  logic             clk_clk = 1'b0;
  logic             reset_reset;
  logic [2:0]       avs_address;
  logic             avs_read;
  logic             avs_write;
  logic [31:0]      avs_writedata;
  logic [31:0]      avs_readdata;
  logic [WIDTH-1:0] led_wire_export;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t        exp_q[$];
  int          n_assert = 0;
  int          n_fail   = 0;
  logic [31:0] ph;

  led_pio_ctrl #(.WIDTH(WIDTH), .DIV_W(DIV_W), .RESET_VAL(RST_V)) dut (
    .clk_clk         (clk_clk),
    .reset_reset     (reset_reset),
    .avs_address     (avs_address),
    .avs_read        (avs_read),
    .avs_write       (avs_write),
    .avs_writedata   (avs_writedata),
    .avs_readdata    (avs_readdata),
    .led_wire_export (led_wire_export)
  );

  always #5 clk_clk = ~clk_clk;

  task automatic push(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    exp_q.push_back(e);
  endtask

  task automatic check_pop(input logic [31:0] obs);
    exp_t e;
    n_assert++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $error("FAIL sb_empty: observed %h, required a queued expectation", obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e.val) else begin
        n_fail++;
        $error("FAIL %s: observed %h required %h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk_clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    avs_address   = a;
    avs_writedata = d;
    avs_write     = 1'b1;
    tick();
    avs_write     = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] exp, input string tag);
    avs_address = a;
    avs_read    = 1'b1;
    push(tag, exp);
    tick();
    avs_read    = 1'b0;
    check_pop(avs_readdata);
  endtask

  task automatic chk_led(input logic [31:0] exp, input string tag);
    push(tag, exp);
    check_pop(32'(led_wire_export));
  endtask

  logic [2:0]  op_addr [4] = '{3'd0, 3'd1, 3'd2, 3'd3};
  logic [31:0] op_data [4] = '{32'hFFFF_FF0F, 32'h30, 32'h01, 32'hFF};
  logic [31:0] op_led  [4] = '{32'h0F, 32'h3F, 32'h3E, 32'hC1};

  initial begin
    reset_reset   = 1'b1;
    avs_address   = '0;
    avs_read      = 1'b0;
    avs_write     = 1'b0;
    avs_writedata = '0;
    repeat (3) tick();
    chk_led(RST_V, "rst_led_held");
    push("rst_readdata_held", 32'h0);
    check_pop(avs_readdata);
    reset_reset = 1'b0;
    tick();
    chk_led(RST_V, "rst_led");
    rd(3'd0, 32'h0000_00A5, "rst_data_rd");
    rd(3'd6, 32'h0, "rst_status_rd");

    // Back-to-back DATA/SET/CLR/TOGGLE; each LED value checked one edge after its write.
    for (int i = 0; i < 4; i++) begin
      avs_address   = op_addr[i];
      avs_writedata = op_data[i];
      avs_write     = 1'b1;
      tick();
      if (i > 0) check_pop(32'(led_wire_export));
      push("atomic_led", op_led[i]);
    end
    avs_write = 1'b0;
    tick();
    check_pop(32'(led_wire_export));
    rd(3'd0, 32'h0000_00C1, "data_after_toggle");
    tick();
    push("rd_hold", 32'h0000_00C1);
    check_pop(avs_readdata);
    rd(3'd1, 32'h0, "set_reads_0");
    rd(3'd3, 32'h0, "toggle_reads_0");

    // Simultaneous read and write of DATA: read sees the pre-write value.
    wr(3'd0, 32'h12);
    avs_address   = 3'd0;
    avs_writedata = 32'h55;
    avs_read      = 1'b1;
    avs_write     = 1'b1;
    push("rw_same_cycle", 32'h12);
    tick();
    avs_read  = 1'b0;
    avs_write = 1'b0;
    check_pop(avs_readdata);
    rd(3'd0, 32'h55, "rw_after");
    chk_led(32'h55, "rw_led");

`ifdef LED_PIO_BLINK_EN
    wr(3'd0, 32'h0);
    wr(3'd4, 32'hFFFF_FF0F);
    rd(3'd4, 32'h0F, "mask_rd");
    wr(3'd5, 32'hFF00_0003);
    avs_address = 3'd6;
    avs_read    = 1'b1;
    for (int j = 1; j <= 14; j++) begin
      ph = 32'(((j - 1) / 4) % 2);
      push("blink_led", (ph != 0) ? 32'h0F : 32'h00);
      push("blink_status", 32'h2 | ph);
      tick();
      check_pop(32'(led_wire_export));
      check_pop(avs_readdata);
    end
    avs_read = 1'b0;
    rd(3'd5, 32'h3, "div_rd_masked");
    wr(3'd5, 32'h0);
    chk_led(32'h0F, "div0_last_on");
    for (int j = 0; j < 8; j++) begin
      tick();
      chk_led(32'h00, "div0_hold");
    end
    rd(3'd6, 32'h0, "div0_status");

    // Shrinking BLINK_DIV below the running count restarts the period.
    wr(3'd5, 32'd20);
    repeat (10) tick();
    wr(3'd5, 32'd2);
    repeat (3) tick();
    chk_led(32'h00, "shrink_pre");
    tick();
    chk_led(32'h0F, "shrink_toggle");
`else
    wr(3'd4, 32'hFF);
    wr(3'd5, 32'h3);
    wr(3'd6, 32'hFF);
    for (int j = 0; j < 6; j++) begin
      tick();
      chk_led(32'h55, "noblink_led");
    end
    rd(3'd4, 32'h0, "noblink_mask_rd");
    rd(3'd5, 32'h0, "noblink_div_rd");
    rd(3'd6, 32'h0, "noblink_status_rd");
`endif

    // Reset asserted with a captured read on the bus.
    wr(3'd0, 32'h3C);
    avs_address = 3'd0;
    avs_read    = 1'b1;
    push("rd_inflight", 32'h3C);
    tick();
    check_pop(avs_readdata);
    #2 reset_reset = 1'b1;
    #1;
    push("rst_mid_readdata", 32'h0);
    check_pop(avs_readdata);
    chk_led(RST_V, "rst_mid_led");
    avs_read = 1'b0;
    #2 reset_reset = 1'b0;
    tick();
    rd(3'd6, 32'h0, "rst_mid_status");
    rd(3'd0, RST_V, "rst_mid_data");
    repeat (8) tick();
    chk_led(RST_V, "rst_mid_led_stable");

    wr(3'd7, 32'hFF);
    rd(3'd0, RST_V, "reserved_wr_ignored");
    rd(3'd7, 32'h0, "reserved_rd");

    if (exp_q.size() != 0) begin
      n_assert++;
      n_fail++;
      $error("FAIL sb_leftover: observed %0d entries, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/led_pio_ctrl.md
# led_pio_ctrl

Parametrised LED/GPIO output peripheral for the Nios II SoC: an Avalon-MM slave that drives `led_wire_export`. It extends the plain output PIO with atomic set/clear/toggle registers and a hardware blink engine, so software no longer needs read-modify-write sequences or timer interrupts. It sits on the Nios data master interconnect next to the SDRAM controller and exports its pins at the top level.

## Interface
Parameters:
- `WIDTH`, 8: output bits, 1..32.
- `DIV_W`, 24: blink divider width, 1..32.
- `RESET_VAL`, 0: DATA register value after reset.

Ports:
- `clk_clk`  in  1  system clock; the only clock.
- `reset_reset`  in  1  asynchronous, active-high reset.
- `avs_address`  in  3  word address.
- `avs_read`  in  1  read strobe.
- `avs_write`  in  1  write strobe.
- `avs_writedata`  in  32  write data.
- `avs_readdata`  out  32  read data, fixed read latency 1.
- `led_wire_export`  out  WIDTH  registered LED/pin outputs.

## Operation
Register map, by word address:
- 0 DATA (rw): output latch.
- 1 SET (w): DATA |= wdata. Reads return 0.
- 2 CLR (w): DATA &= ~wdata. Reads return 0.
- 3 TOGGLE (w): DATA ^= wdata. Reads return 0.
- 4 BLINK_MASK (rw): bits that blink.
- 5 BLINK_DIV (rw): half-period in clocks, DIV_W bits.
- 6 STATUS (ro): bit0 = blink phase, bit1 = blink running (BLINK_DIV != 0).
- 7: reserved. Reads 0, writes ignored.

Write and read rules:
- Write bits at or above WIDTH (DIV_W for BLINK_DIV) are ignored.
- Read bits at or above WIDTH (DIV_W for BLINK_DIV) return 0.

Blink engine:
- Counter `cnt` (DIV_W bits) increments each clock while BLINK_DIV != 0.
- When `cnt == BLINK_DIV`: `cnt` is set to 0 and `phase` inverts. The phase therefore toggles every BLINK_DIV+1 clocks.
- BLINK_DIV == 0: counter and phase are held at 0, and blinking stops.
- Any write to BLINK_DIV clears `cnt` and `phase` on the same edge.

Output:
- `led_wire_export` <= DATA ^ (BLINK_MASK & {WIDTH{phase}}).

## Timing
Reset values:
- DATA = RESET_VAL; BLINK_MASK = 0; BLINK_DIV = 0; cnt = 0; phase = 0.
- `avs_readdata` = 0.
- `led_wire_export` = RESET_VAL[WIDTH-1:0].

Write latency:
- A write sampled at edge k updates its register at edge k.
- `led_wire_export` reflects that write at edge k+1.

Read latency:
- A read sampled at edge k presents data on `avs_readdata` after edge k, valid for the cycle k..k+1.
- `avs_readdata` holds its last value when no read is active.

Boundary conditions:
- Read and write in the same cycle (legal on any address): the read returns the pre-write value, and the write takes effect.
- A phase toggle and a write to DATA/SET/CLR/TOGGLE on the same edge are both applied. The output on the next edge uses the new DATA and the new phase.
- Writing BLINK_DIV smaller than the current `cnt`: cnt is cleared by that write, so no wrap through 2^DIV_W occurs.
- Reset asserted mid-operation: all state returns to its reset value immediately (asynchronous). Any in-flight read returns 0.

## Configuration
- `LED_PIO_BLINK_EN` defined: the blink engine, BLINK_MASK, BLINK_DIV and STATUS are implemented as described above.
- `LED_PIO_BLINK_EN` undefined:
  - Addresses 4-6 read 0 and ignore writes.
  - `phase` is a constant 0 and no counter is synthesised.
  - `led_wire_export` <= DATA.
  - SET/CLR/TOGGLE and all latencies are unchanged.

## Test plan
- Reset release, WIDTH=8, RESET_VAL=8'hA5 -> `led_wire_export`=8'hA5; reading addr 0 returns 32'h000000A5; reading addr 6 returns 0.
- Write DATA=32'hFFFF_FF0F, then SET 8'h30, CLR 8'h01, TOGGLE 8'hFF in consecutive cycles -> LED sequence 0F, 3F, 3E, C1, each one cycle after its write.
- BLINK_MASK=8'h0F, BLINK_DIV=3, DATA=8'h00 -> LED alternates 00/0F every 4 clocks; STATUS bit0 tracks the phase.
- During blinking, write BLINK_DIV=0 -> phase goes to 0 at that edge and LED holds 00 indefinitely.
- Read addr 0 and write DATA=8'h55 in the same cycle, previous DATA=8'h12 -> readdata=8'h12; a following read returns 8'h55.
- Assert reset while blinking, with a read in flight -> readdata=0, LED=RESET_VAL, STATUS=0 immediately. With `LED_PIO_BLINK_EN` undefined, a write to addr 4 has no effect on LED.
